// File: rtl/cdb_arbiter_pkg.sv
// Completion-side constants shared by the ROB, the reservation stations and the CDB arbiter.
// SD is the clock-to-Q delay hook; it expands to nothing so that synthesis sees plain assignments.
`ifndef SD
`define SD
`endif

package cdb_arbiter_pkg;

    localparam int ROB_ENTRIES = 32;
    localparam int TAG_W       = $clog2(ROB_ENTRIES);
    localparam int DATA_W      = 64;
    localparam int REG_W       = 5;
    localparam int NUM_FU      = 4;
    localparam int ID_W        = $clog2(NUM_FU);

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: the first requester at or after ptr, moving upward and wrapping, wins a
// one-hot grant. Purely combinational. N must be a power of two.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_grant
);

    logic [ID_W-1:0] w_idx;

    // NOTE: combinational logic uses blocking '=' and assigns every output a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        w_idx     = ptr;
        for (int k = 0; k < N; k++) begin
            // ptr + k is computed in ID_W bits, so it wraps modulo N.
            w_idx = ptr + ID_W'(k);
            if (!any_grant && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
                any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-side collector in front of the common data bus. Each functional unit has a one-entry
// result slot. One slot per cycle is broadcast on a registered CDB, chosen in round-robin order.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int REG_W  = cdb_arbiter_pkg::REG_W,
    parameter int ID_W   = $clog2(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    input  logic [NUM_FU*REG_W-1:0]  fu_reg,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_value,
    output logic [REG_W-1:0]         cdb_reg,
    output logic [ID_W-1:0]          cdb_fu_id
);

    logic [NUM_FU-1:0] r_slot_valid;
    logic [TAG_W-1:0]  r_slot_tag   [NUM_FU];
    logic [DATA_W-1:0] r_slot_value [NUM_FU];
    logic [REG_W-1:0]  r_slot_reg   [NUM_FU];
    logic [ID_W-1:0]   r_rr_ptr;

    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_value;
    logic [REG_W-1:0]  r_cdb_reg;
    logic [ID_W-1:0]   r_cdb_fu_id;

    logic [NUM_FU-1:0] w_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_any_grant;
    logic [NUM_FU-1:0] w_accept;

    rr_arbiter #(
        .N    (NUM_FU),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req       (r_slot_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .any_grant (w_any_grant)
    );

    // A slot being broadcast this cycle can take a new result at the same edge, so there is no bubble.
    assign fu_ready = {NUM_FU{~flush}} & (~r_slot_valid | w_grant);
    assign w_accept = fu_valid & fu_ready;

    // NOTE: sequential state uses non-blocking '<=', so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot_valid <= '0;
            r_rr_ptr     <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_tag    <= '0;
            r_cdb_value  <= '0;
            r_cdb_reg    <= '0;
            r_cdb_fu_id  <= '0;
        end else if (flush) begin
            // The round-robin pointer is left alone so fairness survives a squash.
            r_slot_valid <= '0;
            r_cdb_valid  <= 1'b0;
        end else begin
            r_slot_valid <= `SD (r_slot_valid & ~w_grant) | w_accept;
            r_cdb_valid  <= `SD w_any_grant;
            if (w_any_grant) begin
                r_rr_ptr    <= `SD w_grant_id + ID_W'(1);
                r_cdb_tag   <= `SD r_slot_tag[w_grant_id];
                r_cdb_value <= `SD r_slot_value[w_grant_id];
                r_cdb_reg   <= `SD r_slot_reg[w_grant_id];
                r_cdb_fu_id <= `SD w_grant_id;
            end
        end
    end

    // NOTE: slot payload storage has no reset; r_slot_valid alone qualifies it, which keeps the wide datapath reset-free.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_accept[i]) begin
                r_slot_tag[i]   <= `SD fu_tag[i*TAG_W +: TAG_W];
                r_slot_value[i] <= `SD fu_value[i*DATA_W +: DATA_W];
                r_slot_reg[i]   <= `SD fu_reg[i*REG_W +: REG_W];
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;
    assign cdb_reg   = r_cdb_reg;
    assign cdb_fu_id = r_cdb_fu_id;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side neighbour of the reorder buffer: collects results from the functional units, holds each in a one-entry slot, and broadcasts one result per cycle on the common data bus (CDB). The CDB marks the tagged ROB entry complete and wakes reservation stations. It arbitrates round-robin, back-pressures each functional unit independently, and discards all held results on a branch-mispredict flush.

## Interface
Parameters:
- NUM_FU, 4: number of functional-unit inputs (power of two, ≥2)
- TAG_W, 5: ROB tag width (32 ROB entries)
- DATA_W, 64: result value width
- REG_W, 5: architectural destination register width
- ID_W, 2: log2(NUM_FU)

Ports:
- clock  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of all held and outgoing results
- fu_valid  in  NUM_FU  bit i: FU i presents a result this cycle
- fu_tag  in  NUM_FU*TAG_W  FU i tag in bits [i*TAG_W +: TAG_W]
- fu_value  in  NUM_FU*DATA_W  FU i result, same packing
- fu_reg  in  NUM_FU*REG_W  FU i destination register, same packing
- fu_ready  out  NUM_FU  bit i: slot i accepts a result this cycle (combinational)
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  ROB tag of broadcast result
- cdb_value  out  DATA_W  broadcast value
- cdb_reg  out  REG_W  broadcast destination register
- cdb_fu_id  out  ID_W  index of the FU whose result is broadcast

## Operation
- Per-FU slot: slot_valid, tag, value, reg. No bypass; every result passes through its slot.
- Accept: slot i loads when fu_valid[i] && fu_ready[i].
- fu_ready[i] = !flush && (!slot_valid[i] || grant[i]). A granted slot reloads in the same cycle with no bubble.
- fu_valid[i] while fu_ready[i]=0: the FU holds its inputs. The arbiter drops nothing.
- Arbitration: combinational over slot_valid. Search starts at rr_ptr and ascends mod NUM_FU. The first valid slot gets the one-hot grant. At most one grant per cycle.
- rr_ptr: on a grant to slot i, becomes (i+1) mod NUM_FU. Unchanged when there is no grant.
- CDB register: on a grant, cdb_valid=1 and tag/value/reg/fu_id load from the granted slot. Otherwise cdb_valid=0 and the data fields hold their previous values.
- Granted slot: clears unless reloaded the same cycle.
- Flush: at the edge, all slot_valid→0 and cdb_valid→0. FU inputs are ignored during the flush cycle. rr_ptr is unchanged. Flush has priority over accept and grant.
- Reset: highest priority. All slot_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag/value/reg/fu_id=0.

## Timing
- Latency: fu_valid accepted in cycle N → slot valid in N+1 → earliest cdb_valid in N+2.
- Throughput: one broadcast per cycle aggregate. A single FU sustains one result per cycle when it is the only requester.
- Starvation bound: a valid slot is broadcast within NUM_FU cycles of becoming valid.
- Outputs after reset: fu_ready = all 1s (combinational, from empty slots), cdb_* all 0.
- Flush in cycle N: cdb_valid=0 in N+1. fu_ready=0 throughout N, all 1s in N+1.
- Reset asserted mid-stream: held results are lost and there is no partial broadcast in the following cycle.

## Structure
- Shared header/package: TAG_W derived from `ROB_ENTRIES`, DATA_W, REG_W, NUM_FU, and the `SD` clock-to-Q delay macro, also used by the ROB and the reservation stations.
- One sub-module: rr_arbiter (parameter N). Inputs req[N] and ptr. Outputs one-hot grant[N], grant_id, and any_grant. Purely combinational.
- The top level holds the slots, rr_ptr and the CDB register.

## Test plan
- Reset → cdb_valid=0, cdb_tag=0, cdb_value=0, fu_ready=4'b1111 in the first cycle after reset deasserts.
- fu_valid=4'b0100 in cycle 1 with tag 7, value 64'hDEADBEEF, reg 3 → cycle 3: cdb_valid=1, tag 7, value 64'hDEADBEEF, reg 3, fu_id 2.
- All four FUs valid in cycle 1 with rr_ptr=0 and tags 1–4 → broadcasts tags 1,2,3,4 in cycles 3–6. fu_ready[3] stays 0 until its grant cycle.
- FU0 alone with fu_valid held high for 8 cycles, tags 0–7 → eight consecutive cdb_valid cycles, tags in order, no bubble.
- FU0 and FU1 continuously valid → cdb_fu_id alternates 0,1,0,1…; neither FU waits more than 2 cycles.
- Slots 0,1,3 full and flush in cycle N → cdb_valid=0 in N+1, no stale tag ever broadcast, fu_ready=4'b1111 in N+1.
